dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_align.sv | 44 ++++
 rtl/dmem_ctrl.sv | 176 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states
// and the legal data_ram read-latency bounds.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int unsigned RAM_LAT_MIN = 1;
  localparam int unsigned RAM_LAT_MAX = 3;

  function automatic logic misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = (lo != 2'b00);
      SZ_RSVD: misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for data_ram: store lane mask and replicated write data,
// plus lane extraction and sign/zero extension of load data.
module dmem_align
  import dmem_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    wen_o   = '0;
    wdata_o = '0;
    rdata_o = '0;
    byte_v  = rdata_i[{lane_i, 3'b000} +: 8];
    half_v  = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: begin
        wen_o   = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        wen_o   = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~unsigned_i & half_v[15]}}, half_v};
      end
      default: begin
        wen_o   = '1;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Memory-stage load/store controller driving a single data_ram port.
// Build option DMEM_MISALIGN_TRAP_EN: flag misaligned/reserved-size requests instead of aligning them.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_err,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [1:0] CNT_INIT = 2'(RAM_LAT - 1);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cnt_q, cnt_d;

  size_e       size_in;
  logic [31:0] addr_in;
  logic        err_in;
  logic        accept;

  logic [3:0]  lane_wen;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  dmem_align u_align (
    .size_i     (size_q),
    .lane_i     (addr_q[1:0]),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (ram_rdata),
    .wen_o      (lane_wen),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

  assign accept = req_valid && req_ready;

  // Request qualification at capture time: either flag it or coerce it aligned.
  always_comb begin
    size_in = size_e'(req_size);
    addr_in = req_addr;
    err_in  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    err_in  = misaligned(size_in, req_addr[1:0]);
`else
    if (size_in == SZ_RSVD) size_in = SZ_WORD;
    case (size_in)
      SZ_HALF: addr_in[0]   = 1'b0;
      SZ_WORD: addr_in[1:0] = 2'b00;
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = err_in ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_d = wr_q ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (cnt_q == 2'd0) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_d    = wr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_d    = req_wr;
          size_d  = size_in;
          uns_d   = req_unsigned;
          addr_d  = addr_in;
          wdata_d = req_wdata;
          err_d   = err_in;
          rdata_d = '0;
        end
      end
      ST_ACCESS: if (!wr_q) cnt_d = CNT_INIT;
      ST_WAIT: begin
        // Counter at zero means ram_rdata holds this load's word now.
        if (cnt_q == 2'd0) rdata_d = lane_rdata;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced quiet while rst is high, whatever the state.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    addr_err   = 1'b0;
    ram_en     = 1'b0;
    ram_wen    = '0;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: req_ready = 1'b1;
        ST_ACCESS: begin
          ram_en    = 1'b1;
          ram_addr  = {addr_q[31:2], 2'b00};
          ram_wen   = wr_q ? lane_wen : 4'b0000;
          ram_wdata = wr_q ? lane_wdata : '0;
        end
        ST_RESP: begin
          resp_valid = 1'b1;
          resp_rdata = rdata_q;
          addr_err   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a RAM_LAT=1 instance against a byte-array
// memory model, plus a RAM_LAT=3 instance for long-latency and reset-abort cases.
module tb_dmem_ctrl;

  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        rst, rst3;
  logic        req_valid, v3;
  logic        req_wr, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready, resp_valid, addr_err, ram_en;
  logic [31:0] resp_rdata, ram_addr, ram_wdata;
  logic [3:0]  ram_wen;
  logic [31:0] ram_rdata;

  logic        ready3, rv3, err3, ren3;
  logic [31:0] rdata3, raddr3, rwdata3, rrdata3;
  logic [3:0]  wen3;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned nwrites = 0;
  int unsigned exp_writes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl #(.RAM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .addr_err(addr_err), .ram_en(ram_en),
    .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  dmem_ctrl #(.RAM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_wr(req_wr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(ready3), .resp_valid(rv3),
    .resp_rdata(rdata3), .addr_err(err3), .ram_en(ren3),
    .ram_wen(wen3), .ram_addr(raddr3), .ram_wdata(rwdata3),
    .ram_rdata(rrdata3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // RAM model for the LAT=1 instance; port signals latched mid-cycle
  logic [7:0]  mem     [0:255];
  logic [7:0]  ref_mem [0:255];
  logic        en_s;
  logic [3:0]  wen_s;
  logic [31:0] addr_s, wdata_s;

  initial for (int i = 0; i < 256; i++) begin
    mem[i]     = 8'(i * 7 + 3);
    ref_mem[i] = 8'(i * 7 + 3);
  end

  always @(negedge clk) begin
    en_s = ram_en; wen_s = ram_wen; addr_s = ram_addr; wdata_s = ram_wdata;
  end

  always @(posedge clk) begin
    if (en_s) begin
      ram_rdata <= {mem[{addr_s[7:2], 2'b11}], mem[{addr_s[7:2], 2'b10}],
                    mem[{addr_s[7:2], 2'b01}], mem[{addr_s[7:2], 2'b00}]};
      for (int j = 0; j < 4; j++)
        if (wen_s[j]) mem[{addr_s[7:2], 2'(j)}] <= wdata_s[8*j +: 8];
    end else begin
      ram_rdata <= 32'hBAD0_BAD0;
    end
  end

  // LAT=3 read pipe: good data only exactly three cycles after ram_en
  logic [31:0] p0 = '0, p1 = '0, p2 = '0;
  logic        ren3_s;
  always @(negedge clk) ren3_s = ren3;
  always @(posedge clk) begin
    p0 <= ren3_s ? 32'hA5C3_0F96 : 32'h0BAD_F00D;
    p1 <= p0;
    p2 <= p1;
  end
  assign rrdata3 = p2;

  typedef struct { logic [31:0] rdata; logic err; int unsigned cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] wen; logic [31:0] wdata; logic wr; } ram_t;
  resp_t rq[$];
  ram_t  mq[$];

  always @(negedge clk) begin
    if (resp_valid) begin
      if (rq.size() == 0) check("resp_spurious", 32'd1, 32'd0);
      else begin
        resp_t e;
        e = rq.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, addr_err}, {31'd0, e.err});
        check("resp_cycle", cyc, e.cyc);
      end
    end
    if (ram_en) begin
      if (mq.size() == 0) check("ram_spurious", ram_addr, 32'hFFFF_FFFF);
      else begin
        ram_t m;
        m = mq.pop_front();
        check("ram_addr", ram_addr, m.addr);
        check("ram_wen", {28'd0, ram_wen}, {28'd0, m.wen});
        if (m.wr) check("ram_wdata", ram_wdata, m.wdata);
      end
      if (ram_wen != 4'b0000) nwrites++;
    end else if (ram_wen != 4'b0000) begin
      check("wen_outside_access", {28'd0, ram_wen}, 32'd0);
    end
  end

  task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic        err;
    logic [1:0]  sz;
    logic [31:0] a, v, rep;
    logic [3:0]  wen;
    int unsigned nb, lat, n;
    resp_t       r;
    ram_t        m;
    sz = size; a = addr;
`ifdef DMEM_MISALIGN_TRAP_EN
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
`else
    err = 1'b0;
    if (sz == 2'd3) sz = 2'd2;
    if (sz == 2'd1) a[0] = 1'b0;
    if (sz == 2'd2) a[1:0] = 2'b00;
`endif
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = '0; wen = '0;
    for (int k = 0; k < 4; k++) rep[8*k +: 8] = wdata[8*(k % nb) +: 8];
    for (int k = 0; k < int'(nb); k++) begin
      wen[a[1:0] + 2'(k)] = 1'b1;
      v[8*k +: 8] = ref_mem[a[7:0] + 8'(k)];
    end
    if (!uns && nb < 4 && v[8*nb-1])
      for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
    if (wr && !err)
      for (int k = 0; k < int'(nb); k++) ref_mem[a[7:0] + 8'(k)] = wdata[8*k +: 8];
    lat = err ? 1 : (wr ? 2 : 2 + LAT);

    req_valid = 1'b1; req_wr = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    r.rdata = (wr || err) ? 32'd0 : v;
    r.err   = err;
    r.cyc   = cyc + lat;
    rq.push_back(r);
    if (!err) begin
      m.addr = {a[31:2], 2'b00}; m.wen = wr ? wen : 4'b0000; m.wdata = rep; m.wr = wr;
      mq.push_back(m);
      if (wr) exp_writes++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned n, cnt;
    logic found;
    rst = 1'b1; rst3 = 1'b1; req_valid = 1'b0; v3 = 1'b0;
    req_wr = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_rdata_err", {resp_rdata[30:0], addr_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'hABCD_EF80);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h5555_8001);
    issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
    issue(1'b0, 2'd3, 1'b1, 32'h10, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h31, 32'h0000_7F7E);
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 5; i++)
      issue(1'b1, 2'd0, 1'b0, 32'h40 + 32'(i), 32'h90 + 32'(i));
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h44, 32'h0);

    req_valid = 1'b0;
    n = 0;
    while (rq.size() != 0 && n < 50) begin @(posedge clk); n++; end
    #1;
    check("drain_resp", rq.size(), 32'd0);
    check("drain_ram", mq.size(), 32'd0);
    check("ram_write_count", nwrites, exp_writes);

    // LAT=3 instance: normal load latency, then reset while waiting
    @(posedge clk); #1 rst3 = 1'b0;
    @(negedge clk);
    check("l3_ready_after_rst", {31'd0, ready3}, 32'd1);
    @(posedge clk); #1;
    req_wr = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100; v3 = 1'b1;
    @(posedge clk); #1 v3 = 1'b0;
    n = 0; found = 1'b0;
    while (!found && n < 12) begin
      @(negedge clk); n++;
      if (rv3) begin
        found = 1'b1;
        check("l3_latency", n, 32'd5);
        check("l3_rdata", rdata3, 32'hA5C3_0F96);
      end
    end
    if (!found) check("l3_timeout", 32'd0, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    v3 = 1'b1;
    @(negedge clk);
    check("l3_ready_before_abort", {31'd0, ready3}, 32'd1);
    @(posedge clk); #1 v3 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst3 = 1'b1;
    @(negedge clk);
    check("l3_rst_outputs", {rv3, ready3, ren3, err3}, 32'd0);
    @(posedge clk); #1 rst3 = 1'b0;
    @(negedge clk);
    check("l3_idle_after_abort", {31'd0, ready3}, 32'd1);
    cnt = 0;
    repeat (8) begin
      if (rv3) cnt++;
      @(negedge clk);
    end
    check("l3_no_resp_after_abort", cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
